// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// in-order response queue toward decode, and redirect flush/drop handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        err_rsp
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_nxt;

  logic [31:0]   fetch_pc, rsp_pc, redirect_pc_a;
  logic [CW-1:0] outstanding, outstanding_nxt, drop_cnt, count;
  logic [PW-1:0] head, tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [CW:0]   credit_used;
  logic          req_fire, rsp_ok, rsp_keep, pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Credit covers both in-flight requests and queued entries, so every
  // accepted request is guaranteed a queue slot when its response returns.
  always_comb begin
    credit_used     = {1'b0, outstanding} + {1'b0, count};
    redirect_pc_a   = redirect_pc & ~32'h3;
    imem_req_valid  = (state == RUN) && (credit_used < DEPTH_C) && !redirect_valid;
    imem_req_addr   = fetch_pc;
    req_fire        = imem_req_valid && imem_req_ready;
    rsp_ok          = imem_rsp_valid && (outstanding != '0);
    rsp_keep        = rsp_ok && (drop_cnt == '0) && !redirect_valid;
    if_valid        = (count != '0);
    pop             = if_valid && if_ready && !redirect_valid;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_ok);
    if_instr        = if_valid ? q_instr[head] : NOP;
    if_pc           = if_valid ? q_pc[head] : rsp_pc;
    if_pc_plus4     = if_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      q_instr[tail] <= imem_rsp_data;
      q_pc[tail]    <= rsp_pc;
    end
  end

  // On redirect every request still in flight is stale, including any
  // response landing this very cycle, hence drop_cnt takes outstanding_nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      err_rsp     <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (imem_rsp_valid && (outstanding == '0)) err_rsp <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc_a;
        rsp_pc   <= redirect_pc_a;
        drop_cnt <= outstanding_nxt;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 32'd4;
          tail   <= tail + PW'(1);
        end
        if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (pop) head <= head + PW'(1);
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency, a
// program-order reference of the expected instruction stream, and directed phases.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic        err_rsp;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .err_rsp(err_rsp)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  pend_t pend[$];
  exp_t  exp_q[$];

  int          mem_mode = 0, lat_min = 1, lat_max = 1;
  logic [31:0] mpc = RESET_PC;
  int          outs = 0, acc_total = 0;
  logic        err_exp = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h0513};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: condition not reached within cycle budget", nm);
  endtask

  // Memory: in-order, one response per cycle, per-request latency in [lat_min,lat_max]
  initial begin
    int lat, due, last_due;
    last_due = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      case (mem_mode)
        0:       imem_req_ready = 1'b1;
        1:       imem_req_ready = ($urandom % 3) != 0;
        default: imem_req_ready = 1'b0;
      endcase
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      #4;
      if (!rst && imem_req_valid && imem_req_ready) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        pend.push_back('{addr: imem_req_addr, due: due});
      end
    end
  end

  // Scoreboard: expected program-order stream, sampled 1 time unit before each rising edge
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [31:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        exp_q.delete();
        mpc        = RESET_PC;
        outs       = 0;
        err_exp    = 1'b0;
        prev_stall = 1'b0;
        continue;
      end
      chk("err_rsp", err_rsp, err_exp);
      if (!if_valid) chk("nop_when_empty", if_instr, NOP);
      if (prev_stall && !redirect_valid) begin
        chk("req_hold_valid", imem_req_valid, 1'b1);
        chk("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (imem_rsp_valid) begin
        if (outs == 0) err_exp = 1'b1;
        else outs--;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, mpc);
        exp_q.push_back('{pc: mpc, instr: memf(mpc)});
        mpc = mpc + 32'd4;
        outs++;
        acc_total++;
      end
      if (redirect_valid) begin
        chk("no_req_on_redirect", imem_req_valid, 1'b0);
        exp_q.delete();
        mpc = redirect_pc & ~32'h3;
      end else if (if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_instr: got pc %h with nothing expected", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.instr);
          chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
        end
      end
      chk("credit_bound", 32'(outs <= DEPTH), 32'd1);
      prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr  = imem_req_addr;
    end
  end

  // Directed phases followed by a randomized run
  initial begin
    int  acc0;
    bit  found;
    rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_if_pc", if_pc, RESET_PC);
    chk("rst_if_pc_plus4", if_pc_plus4, RESET_PC + 32'd4);
    chk("rst_err", err_rsp, 1'b0);
    @(negedge clk); rst = 1'b0;
    #3 chk("boot_no_req", imem_req_valid, 1'b0);
    @(negedge clk); #3;
    chk("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk); #3 chk("if_valid_t2", if_valid, 1'b0);
    @(negedge clk); #3;
    chk("if_valid_t3", if_valid, 1'b1);
    chk("first_if_pc", if_pc, RESET_PC);
    chk("first_if_instr", if_instr, memf(RESET_PC));
    repeat (6) begin
      @(negedge clk); #3 chk("throughput", if_valid, 1'b1);
    end

    // Backpressure: after a redirect with decode stalled, exactly DEPTH fetches
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; if_ready = 1'b0;
    #3 acc0 = acc_total;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    chk("bp_req_count", 32'(acc_total - acc0), 32'(DEPTH));
    chk("bp_req_idle", imem_req_valid, 1'b0);
    @(negedge clk); if_ready = 1'b1;
    repeat (12) @(negedge clk);

    // Redirect with stale requests in flight
    lat_min = 3; lat_max = 3;
    repeat (6) @(negedge clk);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (outs >= 2) begin found = 1; break; end
    end
    if (!found) tmo("stale_setup");
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk); redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      #3;
      if (if_valid) begin found = 1; break; end
      @(negedge clk);
    end
    if (!found) tmo("stale_first_valid");
    else begin
      chk("stale_first_pc", if_pc, 32'h100);
      chk("stale_first_instr", if_instr, memf(32'h100));
    end
    repeat (10) @(negedge clk);

    // Redirect coinciding with a pop and an arriving response
    lat_min = 1; lat_max = 1;
    repeat (10) @(negedge clk);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (imem_rsp_valid && if_valid) begin found = 1; break; end
    end
    if (!found) tmo("coincide_setup");
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk); redirect_valid = 1'b0;
    #3;
    chk("coincide_flush", if_valid, 1'b0);
    chk("coincide_req_valid", imem_req_valid, 1'b1);
    chk("coincide_req_addr", imem_req_addr, 32'h200);
    @(negedge clk);
    @(negedge clk); #3;
    chk("redirect_t3_valid", if_valid, 1'b1);
    chk("redirect_t3_pc", if_pc, 32'h200);
    repeat (6) @(negedge clk);

    // Asynchronous reset with responses still pending
    lat_min = 4; lat_max = 4;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (pend.size() >= 2) begin found = 1; break; end
    end
    if (!found) tmo("areset_setup");
    @(posedge clk); #2;
    rst = 1'b1; mem_mode = 2;
    #1;
    chk("areset_req_valid", imem_req_valid, 1'b0);
    chk("areset_req_addr", imem_req_addr, RESET_PC);
    chk("areset_if_valid", if_valid, 1'b0);
    chk("areset_if_instr", if_instr, NOP);
    chk("areset_if_pc", if_pc, RESET_PC);
    chk("areset_if_pc_plus4", if_pc_plus4, RESET_PC + 32'd4);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    chk("late_rsp_err", err_rsp, 1'b1);
    chk("late_rsp_not_queued", if_valid, 1'b0);
    @(negedge clk); rst = 1'b1; mem_mode = 0; lat_min = 1; lat_max = 1;
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);

    // PC wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); redirect_valid = 1'b0;
    #3 chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); #3 chk("wrap_req_addr1", imem_req_addr, 32'h0000_0000);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (if_valid && if_pc == 32'hFFFF_FFFC) begin found = 1; break; end
      @(negedge clk); #3;
    end
    if (!found) tmo("wrap_entry");
    else chk("wrap_pc_plus4", if_pc_plus4, 32'h0000_0000);
    repeat (6) @(negedge clk);

    // Randomized traffic
    mem_mode = 1; lat_min = 1; lat_max = 4;
    repeat (1500) begin
      @(negedge clk);
      if_ready = ($urandom % 4) != 0;
      if ($urandom % 32 == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(negedge clk);
    redirect_valid = 1'b0; if_ready = 1'b1; mem_mode = 0;
    repeat (30) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
